data_mem_ctrl: RTL
==================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port mem_en  in  1  request valid from control path.
REQ-004 SHALL have port load  in  1  request is a load.
REQ-005 SHALL have port store  in  1  request is a store.
REQ-006 SHALL have port fun3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 SHALL have port addr  in  32  byte address.
REQ-008 SHALL have port wdata  in  32  store data, LSB-aligned.
REQ-009 SHALL have port req_ready  out  1  controller can accept a request.
REQ-010 SHALL have port rsp_valid  out  1  one-cycle response strobe.
REQ-011 SHALL have port rdata  out  32  extended load result.
REQ-012 SHALL have port err  out  1  qualifies rsp_valid: misaligned or illegal fun3.
REQ-013 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 32, mem_wdata out 32, mem_wmask out 4 toward data memory.
REQ-014 SHALL have ports mem_rdata in 32, mem_ack in 1 from data memory.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-016 IDLE: req_ready=1; accept when mem_en=1 and exactly one of load/store=1; otherwise ignore, stay IDLE.
REQ-017 On accept, SHALL latch load/store, fun3, addr, wdata.
REQ-018 Illegal request (load with fun3 011/110/111, store with fun3 not in 000/001/010, H not 2-byte aligned, W not 4-byte aligned) SHALL go IDLE->RESP with no memory access; RESP asserts rsp_valid=1, err=1, rdata=0.
REQ-019 Legal request SHALL go IDLE->ACCESS; in ACCESS, mem_req=1 and mem_we/addr/wdata/wmask held stable until mem_ack=1.
REQ-020 mem_addr SHALL be {addr[31:2],2'b00}.
REQ-021 Store byte: mem_wmask=1<<addr[1:0], mem_wdata=wdata[7:0] replicated x4; half: wmask 0011 (addr[1]=0) or 1100, mem_wdata=wdata[15:0] replicated x2; word: wmask 1111, mem_wdata=wdata.
REQ-022 Loads: mem_we=0, mem_wmask=0000.
REQ-023 On mem_ack in ACCESS, SHALL capture load data: select byte by addr[1:0] or half by addr[1]; sign-extend for 000/001, zero-extend for 100/101; word unchanged; go RESP.
REQ-024 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; rdata held until next response; stores return rdata=0, err=0.
REQ-025 req_ready SHALL be 0 in ACCESS and RESP; mem_en there is ignored (no queueing).
REQ-026 mem_ack outside ACCESS SHALL be ignored.
REQ-027 Latency: mem_ack in same cycle as first mem_req gives rsp_valid 2 cycles after accept edge; each wait cycle adds one.
REQ-028 mem_req SHALL be 0 in IDLE and RESP.

Reset
REQ-029 rst=0 SHALL asynchronously force IDLE, req_ready=1, rsp_valid=0, err=0, rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0.
REQ-030 Reset during ACCESS SHALL drop mem_req immediately, produce no response; first request after release SHALL be accepted normally.

Verification
REQ-031 SW addr=0x100 wdata=0xDEADBEEF, mem_ack after 2 wait cycles -> mem_wmask=1111, mem_addr=0x100 held 3 cycles, rsp_valid err=0 next cycle.
REQ-032 SB addr=0x203 wdata=0x000000A5 -> mem_addr=0x200, mem_wmask=1000, mem_wdata=0xA5A5A5A5.
REQ-033 LB addr=0x301, mem_rdata=0x1234_80FF -> rdata=0xFFFFFF80; LBU same -> 0x00000080; LHU addr=0x302 -> 0x00001234.
REQ-034 LW addr=0x102 -> no mem_req, rsp_valid=1 err=1 rdata=0 one cycle after accept.
REQ-035 mem_en with load=store=1, and mem_en during ACCESS -> ignored, no state change.
REQ-036 rst low mid-ACCESS, then LW addr=0x0 mem_rdata=0x55AA55AA -> mem_req falls asynchronously, no rsp_valid; post-reset rdata=0x55AA55AA err=0.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Load/store unit front end: decodes size/sign, aligns store lanes,
// runs a single outstanding access to data memory and extends load data.
module data_mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        load,
    input  logic        store,
    input  logic [2:0]  fun3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] ACCESS = 2'b01;
    localparam logic [1:0] RESP   = 2'b10;

    logic [1:0]  state;
    logic        is_load_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wd_q;
    logic [3:0]  mask_q;

    logic        accept;
    logic        f3_ok;
    logic        misal;
    logic        bad_req;
    logic [3:0]  st_mask;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign accept  = (state == IDLE) && mem_en && (load ^ store);
    assign bad_req = !f3_ok || misal;

    // Stores only allow B/H/W; loads additionally allow BU/HU.
    always_comb begin
        f3_ok = 1'b0;
        misal = 1'b0;
        case (fun3)
            3'b000: f3_ok = 1'b1;
            3'b001: begin
                f3_ok = 1'b1;
                misal = addr[0];
            end
            3'b010: begin
                f3_ok = 1'b1;
                misal = |addr[1:0];
            end
            3'b100: f3_ok = load;
            3'b101: begin
                f3_ok = load;
                misal = addr[0];
            end
            default: f3_ok = 1'b0;
        endcase
    end

    always_comb begin
        st_mask = 4'b1111;
        st_data = wdata;
        case (fun3[1:0])
            2'b00: begin
                st_mask = 4'b0001 << addr[1:0];
                st_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                st_mask = addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata[15:0]}};
            end
            default: begin
                st_mask = 4'b1111;
                st_data = wdata;
            end
        endcase
    end

    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (off_q)
            2'd0: ld_byte = mem_rdata[7:0];
            2'd1: ld_byte = mem_rdata[15:8];
            2'd2: ld_byte = mem_rdata[23:16];
            2'd3: ld_byte = mem_rdata[31:24];
            default: ld_byte = mem_rdata[7:0];
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            is_load_q <= 1'b0;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            err_q     <= 1'b0;
            rdata_q   <= 32'd0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wd_q      <= 32'd0;
            mask_q    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_load_q <= load;
                        f3_q      <= fun3;
                        off_q     <= addr[1:0];
                        if (bad_req) begin
                            state   <= RESP;
                            err_q   <= 1'b1;
                            rdata_q <= 32'd0;
                        end else begin
                            state  <= ACCESS;
                            addr_q <= {addr[31:2], 2'b00};
                            we_q   <= store;
                            mask_q <= store ? st_mask : 4'd0;
                            wd_q   <= store ? st_data : 32'd0;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ack) begin
                        state   <= RESP;
                        err_q   <= 1'b0;
                        rdata_q <= is_load_q ? ld_data : 32'd0;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign err       = rsp_valid && err_q;
    assign rdata     = rdata_q;
    assign mem_req   = (state == ACCESS);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wd_q;
    assign mem_wmask = mask_q;

endmodule
